// File: rtl/spi_frame_sequencer_if.sv
// rtl/spi_frame_sequencer_if.sv - command and SPI pin bundle for the frame sequencer
interface spi_frame_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              wait_en;
    logic              wait_trig;
    logic              busy;
    logic              frame_done;

    modport master (
        input  cmd_valid, cmd_data, wait_trig,
        output cmd_ready, sclk, mosi, cs_n, wait_en, busy, frame_done
    );

    modport slave (
        output cmd_valid, cmd_data, wait_trig,
        input  cmd_ready, sclk, mosi, cs_n, wait_en, busy, frame_done
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - mode-0 SPI master shifting one command word per frame with gap-timer handshake
module spi_frame_sequencer #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_frame_sequencer_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    // Holds only the bits not yet on mosi; the MSB goes straight to mosi at accept.
    logic [DATA_W-2:0] shreg;
    logic              div_tc;

    assign div_tc        = (div_cnt == DIV_LAST);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            bus.sclk       <= 1'b0;
            bus.mosi       <= 1'b0;
            bus.cs_n       <= 1'b1;
            bus.wait_en    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        shreg    <= bus.cmd_data[DATA_W-2:0];
                        bus.mosi <= bus.cmd_data[DATA_W-1];
                        bus.cs_n <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        if (!bus.sclk) begin
                            bus.sclk <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit or finish after the last one.
                            bus.sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                bus.mosi <= 1'b0;
                                state    <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + BIT_W'(1);
                                bus.mosi <= shreg[DATA_W-2];
                                shreg    <= shreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (div_tc) begin
                        div_cnt     <= '0;
                        bus.cs_n    <= 1'b1;
                        bus.wait_en <= 1'b1;
                        state       <= GAP;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (bus.wait_trig) begin
                        bus.wait_en    <= 1'b0;
                        bus.frame_done <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb/tb_spi_frame_sequencer.sv - directed self-checking bench for spi_frame_sequencer
module tb_spi_frame_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;

    always #5 clk = ~clk;

    spi_frame_sequencer_if #(.DATA_W(16)) ifa ();
    spi_frame_sequencer_if #(.DATA_W(16)) ifb ();

    spi_frame_sequencer #(.DATA_W(16), .CLK_DIV(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    spi_frame_sequencer #(.DATA_W(16), .CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    // Gap timer models and slave-side monitors, index 0 = dut_a, 1 = dut_b
    logic        auto_trig[2] = '{1'b0, 1'b0};
    logic        stray_trig[2];
    int          gcnt[2];
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    logic        prev_cs[2]   = '{1'b1, 1'b1};
    logic [15:0] rx_word[2];
    int          rx_bits[2], cs_cnt[2], cs_len[2], frame_cnt[2], done_cnt[2];
    int          sclk_bad[2], fall_cyc[2], done_cyc[2];
    logic [15:0] word_log[2][16];
    int          bits_log[2][16];

    assign ifa.wait_trig = auto_trig[0] | stray_trig[0];
    assign ifb.wait_trig = auto_trig[1] | stray_trig[1];

    always @(posedge clk) cyc++;

    task automatic mon(input int k, input logic sclk, input logic mosi, input logic cs_n, input logic fdone);
        if (prev_cs[k] && !cs_n) begin
            rx_word[k] = '0; rx_bits[k] = 0; cs_cnt[k] = 0; fall_cyc[k] = cyc;
        end
        if (!cs_n) cs_cnt[k]++;
        if (!prev_cs[k] && cs_n) begin
            cs_len[k] = cs_cnt[k];
            word_log[k][frame_cnt[k] % 16] = rx_word[k];
            bits_log[k][frame_cnt[k] % 16] = rx_bits[k];
            frame_cnt[k]++;
        end
        if (!prev_sclk[k] && sclk) begin
            rx_word[k] = {rx_word[k][14:0], mosi};
            rx_bits[k]++;
        end
        if (sclk && cs_n) sclk_bad[k]++;
        if (fdone) begin done_cnt[k]++; done_cyc[k] = cyc; end
        prev_sclk[k] = sclk;
        prev_cs[k]   = cs_n;
    endtask

    always @(negedge clk) begin
        logic we;
        mon(0, ifa.sclk, ifa.mosi, ifa.cs_n, ifa.frame_done);
        mon(1, ifb.sclk, ifb.mosi, ifb.cs_n, ifb.frame_done);
        for (int k = 0; k < 2; k++) begin
            we = (k == 0) ? ifa.wait_en : ifb.wait_en;
            if (rst || !we) begin gcnt[k] = 0; auto_trig[k] = 1'b0; end
            else if (gcnt[k] == 30) auto_trig[k] = 1'b1;
            else gcnt[k]++;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int k);
        return (k == 0) ? ifa.busy : ifb.busy;
    endfunction

    task automatic send(input int k, input logic [15:0] d);
        if (k == 0) begin ifa.cmd_valid = 1'b1; ifa.cmd_data = d; end
        else        begin ifb.cmd_valid = 1'b1; ifb.cmd_data = d; end
        for (int i = 0; i < 50 && !busy_of(k); i++) tick;
        if (k == 0) ifa.cmd_valid = 1'b0; else ifb.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int k, input int target);
        for (int i = 0; i < 2000 && done_cnt[k] < target; i++) tick;
        total_cnt++;
        if (done_cnt[k] < target) $display("FAIL wait_done_timeout[%0d]: got %0d frame_done expected %0d", k, done_cnt[k], target);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifa.cmd_valid = 1'b0; ifa.cmd_data = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_data = '0;
        stray_trig[0] = 1'b0; stray_trig[1] = 1'b0;
        repeat (3) tick;
        total_cnt++;
        if ({ifa.cs_n, ifa.sclk, ifa.mosi, ifa.wait_en, ifa.frame_done, ifa.busy} !== 6'b100000)
            $display("FAIL reset_outputs: got %b expected 100000", {ifa.cs_n, ifa.sclk, ifa.mosi, ifa.wait_en, ifa.frame_done, ifa.busy});
        else pass_cnt++;
        rst = 1'b0;
        tick;
        total_cnt++;
        if ({ifa.cmd_ready, ifb.cmd_ready} !== 2'b11) $display("FAIL reset_cmd_ready: got %b expected 11", {ifa.cmd_ready, ifb.cmd_ready});
        else pass_cnt++;
    endtask

    task automatic test_single_frame;
        int f0 = frame_cnt[0];
        int d0 = done_cnt[0];
        send(0, 16'hA5C3);
        wait_done(0, d0 + 1);
        repeat (3) tick;
        total_cnt++;
        if (word_log[0][f0 % 16] !== 16'hA5C3) $display("FAIL single_word: got %h expected a5c3", word_log[0][f0 % 16]);
        else pass_cnt++;
        total_cnt++;
        if (bits_log[0][f0 % 16] !== 16) $display("FAIL single_rising_edges: got %0d expected 16", bits_log[0][f0 % 16]);
        else pass_cnt++;
        total_cnt++;
        if (cs_len[0] !== 68) $display("FAIL single_cs_low: got %0d expected 68", cs_len[0]);
        else pass_cnt++;
        total_cnt++;
        if ({sclk_bad[0], done_cnt[0]} !== {32'd0, 32'(d0 + 1)})
            $display("FAIL single_idle_sclk_done: got sclk_bad=%0d done=%0d expected 0 %0d", sclk_bad[0], done_cnt[0], d0 + 1);
        else pass_cnt++;
    endtask

    task automatic test_gap_handshake;
        int f0 = frame_cnt[0];
        int d0 = done_cnt[0];
        send(0, 16'h0F0F);
        for (int i = 0; i < 500 && !(ifa.cs_n && frame_cnt[0] > f0); i++) tick;
        total_cnt++;
        if ({ifa.wait_en, ifa.frame_done, ifa.busy, ifa.cmd_ready} !== 4'b1010)
            $display("FAIL gap_entry: got en/done/busy/ready=%b expected 1010", {ifa.wait_en, ifa.frame_done, ifa.busy, ifa.cmd_ready});
        else pass_cnt++;
        for (int i = 0; i < 200 && !ifa.wait_trig; i++) tick;
        total_cnt++;
        if ({ifa.wait_trig, ifa.wait_en, ifa.frame_done} !== 3'b110)
            $display("FAIL gap_trigger_seen: got trig/en/done=%b expected 110", {ifa.wait_trig, ifa.wait_en, ifa.frame_done});
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ifa.wait_en, ifa.frame_done, ifa.cmd_ready, ifa.busy} !== 4'b0110)
            $display("FAIL gap_complete: got en/done/ready/busy=%b expected 0110", {ifa.wait_en, ifa.frame_done, ifa.cmd_ready, ifa.busy});
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({ifa.frame_done, done_cnt[0]} !== {1'b0, 32'(d0 + 1)})
            $display("FAIL gap_single_pulse: got done=%b count=%0d expected 0 %0d", ifa.frame_done, done_cnt[0], d0 + 1);
        else pass_cnt++;
        total_cnt++;
        if (word_log[0][f0 % 16] !== 16'h0F0F) $display("FAIL gap_word: got %h expected 0f0f", word_log[0][f0 % 16]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int f0 = frame_cnt[0];
        int d0 = done_cnt[0];
        int bad_ready = 0;
        int dc;
        ifa.cmd_valid = 1'b1; ifa.cmd_data = 16'h0001;
        for (int i = 0; i < 50 && !ifa.busy; i++) tick;
        ifa.cmd_data = 16'hFFFF;
        for (int i = 0; i < 2000 && done_cnt[0] == d0; i++) begin
            if (ifa.cmd_ready) bad_ready++;
            tick;
        end
        dc = done_cyc[0];
        for (int i = 0; i < 50 && !ifa.busy; i++) tick;
        ifa.cmd_valid = 1'b0;
        wait_done(0, d0 + 2);
        total_cnt++;
        if (bad_ready !== 0) $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", bad_ready);
        else pass_cnt++;
        total_cnt++;
        if ({word_log[0][f0 % 16], word_log[0][(f0 + 1) % 16]} !== 32'h0001_FFFF)
            $display("FAIL b2b_words: got %h %h expected 0001 ffff", word_log[0][f0 % 16], word_log[0][(f0 + 1) % 16]);
        else pass_cnt++;
        total_cnt++;
        if ((fall_cyc[0] - dc >= 1) !== 1'b1) $display("FAIL b2b_cs_after_done: got %0d cycles expected >=1", fall_cyc[0] - dc);
        else pass_cnt++;
    endtask

    task automatic test_busy_protection;
        int f0 = frame_cnt[0];
        int d0 = done_cnt[0];
        send(0, 16'h8000);
        for (int i = 0; i < 50 && !ifa.sclk; i++) tick;
        ifa.cmd_valid = 1'b1; ifa.cmd_data = 16'h1234;
        repeat (3) tick;
        ifa.cmd_valid = 1'b0;
        wait_done(0, d0 + 1);
        repeat (100) tick;
        total_cnt++;
        if (word_log[0][f0 % 16] !== 16'h8000) $display("FAIL busy_word: got %h expected 8000", word_log[0][f0 % 16]);
        else pass_cnt++;
        total_cnt++;
        if ({frame_cnt[0], ifa.busy} !== {32'(f0 + 1), 1'b0})
            $display("FAIL busy_no_extra_frame: got frames=%0d busy=%b expected %0d 0", frame_cnt[0], ifa.busy, f0 + 1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        int f0;
        int d0 = done_cnt[0];
        send(0, 16'hFFFF);
        for (int i = 0; i < 200 && rx_bits[0] < 7; i++) tick;
        total_cnt++;
        if ({ifa.cs_n, ifa.mosi} !== 2'b01) $display("FAIL rstmid_pre: got cs_n/mosi=%b expected 01", {ifa.cs_n, ifa.mosi});
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({ifa.cs_n, ifa.sclk, ifa.mosi, ifa.wait_en, ifa.busy, ifa.frame_done} !== 6'b100000)
            $display("FAIL rstmid_async: got %b expected 100000", {ifa.cs_n, ifa.sclk, ifa.mosi, ifa.wait_en, ifa.busy, ifa.frame_done});
        else pass_cnt++;
        repeat (3) tick;
        rst = 1'b0;
        repeat (40) tick;
        total_cnt++;
        if ({ifa.cmd_ready, done_cnt[0]} !== {1'b1, 32'(d0)})
            $display("FAIL rstmid_after: got ready=%b done=%0d expected 1 %0d", ifa.cmd_ready, done_cnt[0], d0);
        else pass_cnt++;
        f0 = frame_cnt[0];
        send(0, 16'h5555);
        wait_done(0, d0 + 1);
        total_cnt++;
        if ({word_log[0][f0 % 16], 16'(bits_log[0][f0 % 16])} !== {16'h5555, 16'd16})
            $display("FAIL rstmid_new_frame: got %h bits=%0d expected 5555 16", word_log[0][f0 % 16], bits_log[0][f0 % 16]);
        else pass_cnt++;
    endtask

    task automatic test_stray_trigger;
        int d0 = done_cnt[0];
        int db = done_cnt[1];
        int fb = frame_cnt[1];
        stray_trig[0] = 1'b1;
        tick;
        stray_trig[0] = 1'b0;
        repeat (3) tick;
        total_cnt++;
        if ({ifa.busy, ifa.frame_done, ifa.cs_n, ifa.wait_en, done_cnt[0]} !== {4'b0010, 32'(d0)})
            $display("FAIL stray_idle: got busy/done/cs_n/en=%b count=%0d expected 0010 %0d",
                     {ifa.busy, ifa.frame_done, ifa.cs_n, ifa.wait_en}, done_cnt[0], d0);
        else pass_cnt++;
        send(1, 16'hC001);
        for (int i = 0; i < 50 && !ifb.sclk; i++) tick;
        stray_trig[1] = 1'b1;
        tick;
        stray_trig[1] = 1'b0;
        total_cnt++;
        if ({ifb.busy, ifb.cs_n, done_cnt[1]} !== {2'b10, 32'(db)})
            $display("FAIL stray_shift: got busy/cs_n=%b count=%0d expected 10 %0d", {ifb.busy, ifb.cs_n}, done_cnt[1], db);
        else pass_cnt++;
        wait_done(1, db + 1);
        repeat (3) tick;
        total_cnt++;
        if (word_log[1][fb % 16] !== 16'hC001) $display("FAIL div1_word: got %h expected c001", word_log[1][fb % 16]);
        else pass_cnt++;
        total_cnt++;
        if ({cs_len[1], bits_log[1][fb % 16], done_cnt[1]} !== {32'd34, 32'd16, 32'(db + 1)})
            $display("FAIL div1_timing: got cs_low=%0d bits=%0d done=%0d expected 34 16 %0d",
                     cs_len[1], bits_log[1][fb % 16], done_cnt[1], db + 1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_gap_handshake;
        test_back_to_back;
        test_busy_protection;
        test_reset_mid_frame;
        test_stray_trigger;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
